host_cmd_master: RTL and testbench
==================================

# host_cmd_master

Host-side command initiator for the UART register/ALU control protocol. It accepts one parallel command at a time, serialises it into the byte frame the system controller decodes, and streams the bytes to the UART transmitter. It then collects the 1- or 2-byte reply from the UART receiver and returns it as a single parallel response. It sits on the host/test side of the UART link, opposite the system controller.

## Interface
- `data_width`, 8, byte width of every frame byte and of the operands
- `addre_width`, 4, register-file address width; zero-extended into a byte
- `alu_func_width`, 4, ALU function width; zero-extended into a byte
- `timeout_width`, 16, width of the reply timeout counter
- `timeout_cycles`, 16'hFFFF, idle cycles allowed between reply bytes before abort
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE; command accepted when `cmd_valid & cmd_ready`
- `cmd_op`  in  2  0=reg write (0xAA), 1=reg read (0xBB), 2=ALU with operands (0xCC), 3=ALU without operands (0xDD)
- `cmd_addr`  in  addre_width  register address (ops 0, 1)
- `cmd_wdata`  in  data_width  write data (op 0)
- `cmd_opa`, `cmd_opb`  in  data_width  ALU operands (op 2)
- `cmd_func`  in  alu_func_width  ALU function (ops 2, 3)
- `tx_p_data`  out  data_width  frame byte to UART TX
- `tx_d_valid`  out  1  frame byte valid; held until `tx_ready`
- `tx_ready`  in  1  UART TX accepts the byte this cycle
- `rx_p_data`  in  data_width  reply byte from UART RX
- `rx_d_valid`  in  1  one-cycle pulse per received byte
- `rsp_data`  out  2*data_width  reply; read result in low byte with upper byte 0; ALU result LSB-first assembled
- `rsp_valid`  out  1  one-cycle pulse when `rsp_data` is complete
- `cmd_done`  out  1  one-cycle pulse at end of every command (success or error)
- `cmd_err`  out  1  valid with `cmd_done`; 1 = reply timeout

## Operation
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE: `cmd_ready`=1. On accept, capture all command fields and build the frame:
  - op0: AA, addr, wdata (3 bytes, no reply)
  - op1: BB, addr (2 bytes, 1 reply byte)
  - op2: CC, opa, opb, func (4 bytes, 2 reply bytes)
  - op3: DD, func (2 bytes, 2 reply bytes)
- SEND: a byte index counts through the frame. The byte advances on each `tx_d_valid & tx_ready`. After the last byte handshake:
  - op0 goes to DONE.
  - Other ops clear the reply byte count and the timeout counter, then go to WAIT_RSP.
- WAIT_RSP:
  - Each `rx_d_valid` stores `rx_p_data`. The first byte goes to `rsp_data[7:0]`; the second goes to `rsp_data[15:8]`. Each byte reloads the timeout counter.
  - When the expected count is reached: `rsp_valid`=1, go to DONE.
  - If the counter reaches `timeout_cycles`: go to DONE with error. `rsp_valid` is not asserted and partial `rsp_data` is retained.
- DONE: `cmd_done`=1 and `cmd_err` are set for one cycle, then go to IDLE.
- `rx_d_valid` outside WAIT_RSP is ignored, including in the cycle of the last TX handshake.
- `rsp_data` is cleared on command accept.
- Address and function are zero-extended to `data_width`.

## Timing
- Reset: synchronous, active-low, takes effect on the next clock edge. It applies regardless of state, including mid-frame. On reset:
  - state=IDLE
  - `tx_d_valid`=0, `tx_p_data`=0
  - `rsp_data`=0, `rsp_valid`=0
  - `cmd_done`=0, `cmd_err`=0
  - `cmd_ready`=1 in the first cycle after reset
  - No partial frame resumes.
- Accept in cycle N: `tx_d_valid`=1 with the opcode byte in cycle N+1.
- `tx_p_data` is stable while `tx_d_valid & !tx_ready`.
- After a handshake in cycle M, the next byte is presented in M+1 with `tx_d_valid` still high (no bubble).
- After the last byte handshake in cycle M, `tx_d_valid`=0 from M+1.
- op0: `cmd_done` in cycle M+1 (DONE); `cmd_ready` in M+2.
- Replies: the final `rx_d_valid` in cycle R gives `rsp_valid` and `cmd_done` together in R+1; `cmd_ready` in R+2.
- Timeout: `cmd_done`/`cmd_err` are high `timeout_cycles`+1 cycles after the last TX handshake or the last reply byte.
- `cmd_ready`=0 in SEND, WAIT_RSP and DONE. `cmd_valid` in DONE is not accepted.
- All outputs are registered except `cmd_ready`, which is decoded from state.

## Test plan
- Write: op0, addr=4'h5, wdata=8'h3C, `tx_ready`=1 -> bytes AA, 05, 3C on three consecutive cycles. `cmd_done`=1 with `cmd_err`=0 one cycle later; no `rsp_valid`.
- Read: op1, addr=4'hA -> bytes BB, 0A. Reply byte 5A arrives after 20 cycles -> next cycle `rsp_valid`=1 with `rsp_data`=16'h005A and `cmd_done`=1.
- ALU: op2, opa=8'h12, opb=8'h34, func=4'h2 -> bytes CC, 12, 34, 02. Reply bytes 46 then 00 -> `rsp_data`=16'h0046 and `rsp_valid` pulse. Then op3 with func=4'h3 -> bytes DD, 03.
- Backpressure: op2 with `tx_ready` low for 3 cycles on each byte -> each byte held stable for 4 cycles; no byte is lost or duplicated; order is unchanged.
- Timeout: `timeout_cycles`=10, op1, no reply -> `cmd_done`=1 with `cmd_err`=1 exactly 11 cycles after the last handshake. `rsp_valid` stays 0. A late reply byte in IDLE is ignored.
- Reset mid-frame: assert `rst`=0 after the second byte of an op2 frame -> `tx_d_valid`=0 on the next edge and `cmd_ready`=1 after release. A new op0 then sends a clean AA frame.

Source files
------------

// File: rtl/host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : host_cmd_master
// Purpose  : Serialises one parallel command into a UART byte frame, then
//            collects the 1- or 2-byte reply and returns it in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module host_cmd_master #(
    parameter int                         data_width     = 8,
    parameter int                         addre_width    = 4,
    parameter int                         alu_func_width = 4,
    parameter int                         timeout_width  = 16,
    parameter logic [timeout_width-1:0]   timeout_cycles = {timeout_width{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [addre_width-1:0]        cmd_addr,
    input  logic [data_width-1:0]         cmd_wdata,
    input  logic [data_width-1:0]         cmd_opa,
    input  logic [data_width-1:0]         cmd_opb,
    input  logic [alu_func_width-1:0]     cmd_func,
    output logic [data_width-1:0]         tx_p_data,
    output logic                          tx_d_valid,
    input  logic                          tx_ready,
    input  logic [data_width-1:0]         rx_p_data,
    input  logic                          rx_d_valid,
    output logic [2*data_width-1:0]       rsp_data,
    output logic                          rsp_valid,
    output logic                          cmd_done,
    output logic                          cmd_err
);

    localparam logic [data_width-1:0]    c_OP_WR   = data_width'(8'hAA);
    localparam logic [data_width-1:0]    c_OP_RD   = data_width'(8'hBB);
    localparam logic [data_width-1:0]    c_OP_ALU  = data_width'(8'hCC);
    localparam logic [data_width-1:0]    c_OP_ALUN = data_width'(8'hDD);
    localparam logic [timeout_width-1:0] c_TMO_ONE = timeout_width'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    logic [data_width-1:0]      r_frame [4];
    logic [1:0]                 r_last_idx;
    logic [1:0]                 r_byte_idx;
    logic [1:0]                 r_rsp_len;
    logic [1:0]                 r_rsp_cnt;
    logic [timeout_width-1:0]   r_tmo_cnt;
    logic [data_width-1:0]      r_tx_p_data;
    logic                       r_tx_d_valid;
    logic [2*data_width-1:0]    r_rsp_data;
    logic                       r_rsp_valid;
    logic                       r_cmd_done;
    logic                       r_cmd_err;

    logic [data_width-1:0]      w_frame [4];
    logic [1:0]                 w_last_idx;
    logic [1:0]                 w_rsp_len;
    logic                       w_accept;
    logic                       w_tx_hs;
    logic                       w_tx_last;
    logic                       w_rx_byte;
    logic                       w_rsp_full;
    logic [timeout_width-1:0]   w_tmo_next;
    logic                       w_timeout;

    // Frame layout and expected reply length, decoded from the live command.
    always_comb begin
        w_frame[0] = c_OP_WR;
        w_frame[1] = '0;
        w_frame[2] = '0;
        w_frame[3] = '0;
        w_last_idx = 2'd2;
        w_rsp_len  = 2'd0;
        case (cmd_op)
            2'd0: begin
                w_frame[0] = c_OP_WR;
                w_frame[1] = data_width'(cmd_addr);
                w_frame[2] = cmd_wdata;
                w_last_idx = 2'd2;
                w_rsp_len  = 2'd0;
            end
            2'd1: begin
                w_frame[0] = c_OP_RD;
                w_frame[1] = data_width'(cmd_addr);
                w_last_idx = 2'd1;
                w_rsp_len  = 2'd1;
            end
            2'd2: begin
                w_frame[0] = c_OP_ALU;
                w_frame[1] = cmd_opa;
                w_frame[2] = cmd_opb;
                w_frame[3] = data_width'(cmd_func);
                w_last_idx = 2'd3;
                w_rsp_len  = 2'd2;
            end
            default: begin
                w_frame[0] = c_OP_ALUN;
                w_frame[1] = data_width'(cmd_func);
                w_last_idx = 2'd1;
                w_rsp_len  = 2'd2;
            end
        endcase
    end

    assign w_accept   = cmd_valid & (r_state == S_IDLE);
    assign w_tx_hs    = r_tx_d_valid & tx_ready;
    assign w_tx_last  = w_tx_hs & (r_byte_idx == r_last_idx);
    // Reply bytes only count while waiting; stray bytes elsewhere are dropped.
    assign w_rx_byte  = rx_d_valid & (r_state == S_WAIT_RSP);
    assign w_rsp_full = w_rx_byte & ((r_rsp_cnt + 2'd1) == r_rsp_len);
    assign w_tmo_next = r_tmo_cnt + c_TMO_ONE;
    assign w_timeout  = (r_state == S_WAIT_RSP) & ~rx_d_valid & (w_tmo_next == timeout_cycles);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next_state = S_SEND;
            S_SEND:     if (w_tx_last) w_next_state = (r_rsp_len == 2'd0) ? S_DONE : S_WAIT_RSP;
            S_WAIT_RSP: if (w_rsp_full || w_timeout) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_frame      <= '{default: '0};
            r_last_idx   <= 2'd0;
            r_byte_idx   <= 2'd0;
            r_rsp_len    <= 2'd0;
            r_rsp_cnt    <= 2'd0;
            r_tmo_cnt    <= '0;
            r_tx_p_data  <= '0;
            r_tx_d_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_valid  <= 1'b0;
            r_cmd_done   <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_rsp_valid <= w_rsp_full;
            r_cmd_done  <= (w_next_state == S_DONE);
            r_cmd_err   <= w_timeout;

            if (w_accept) begin
                r_frame      <= w_frame;
                r_last_idx   <= w_last_idx;
                r_rsp_len    <= w_rsp_len;
                r_byte_idx   <= 2'd0;
                r_tx_p_data  <= w_frame[0];
                r_tx_d_valid <= 1'b1;
                r_rsp_data   <= '0;
            end

            if (w_tx_hs) begin
                if (w_tx_last) begin
                    r_tx_d_valid <= 1'b0;
                    r_rsp_cnt    <= 2'd0;
                    r_tmo_cnt    <= '0;
                end else begin
                    r_byte_idx  <= r_byte_idx + 2'd1;
                    r_tx_p_data <= r_frame[r_byte_idx + 2'd1];
                end
            end

            // Reply assembled LSB-first; a timeout keeps whatever arrived.
            if (r_state == S_WAIT_RSP) begin
                if (w_rx_byte) begin
                    if (r_rsp_cnt == 2'd0) begin
                        r_rsp_data[data_width-1:0] <= rx_p_data;
                    end else begin
                        r_rsp_data[2*data_width-1:data_width] <= rx_p_data;
                    end
                    r_rsp_cnt <= r_rsp_cnt + 2'd1;
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= w_tmo_next;
                end
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign tx_p_data  = r_tx_p_data;
    assign tx_d_valid = r_tx_d_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_valid  = r_rsp_valid;
    assign cmd_done   = r_cmd_done;
    assign cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_cmd_master
// Purpose  : Self-checking bench for host_cmd_master against a frame/reply model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_cmd_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready, tx_d_valid, tx_ready, rx_d_valid;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr, cmd_func;
    logic [7:0]  cmd_wdata, cmd_opa, cmd_opb, tx_p_data, rx_p_data;
    logic [15:0] rsp_data;
    logic        rsp_valid, cmd_done, cmd_err;

    logic        t_cmd_valid, t_cmd_ready, t_tx_d_valid, t_tx_ready, t_rx_d_valid;
    logic [1:0]  t_cmd_op;
    logic [3:0]  t_cmd_addr, t_cmd_func;
    logic [7:0]  t_cmd_wdata, t_cmd_opa, t_cmd_opb, t_tx_p_data, t_rx_p_data;
    logic [15:0] t_rsp_data;
    logic        t_rsp_valid, t_cmd_done, t_cmd_err;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q [$];
    int          exp_nrsp;

    host_cmd_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_func(cmd_func),
        .tx_p_data(tx_p_data), .tx_d_valid(tx_d_valid), .tx_ready(tx_ready),
        .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid), .rsp_data(rsp_data),
        .rsp_valid(rsp_valid), .cmd_done(cmd_done), .cmd_err(cmd_err)
    );

    host_cmd_master #(.timeout_cycles(16'd10)) dut_t (
        .clk(clk), .rst(rst), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_op(t_cmd_op), .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata),
        .cmd_opa(t_cmd_opa), .cmd_opb(t_cmd_opb), .cmd_func(t_cmd_func),
        .tx_p_data(t_tx_p_data), .tx_d_valid(t_tx_d_valid), .tx_ready(t_tx_ready),
        .rx_p_data(t_rx_p_data), .rx_d_valid(t_rx_d_valid), .rsp_data(t_rsp_data),
        .rsp_valid(t_rsp_valid), .cmd_done(t_cmd_done), .cmd_err(t_cmd_err)
    );

    // Reference: the byte list a command must produce and how many reply bytes follow.
    function automatic void model_cmd(input logic [1:0] op, input logic [3:0] addr,
                                      input logic [7:0] wdata, input logic [7:0] opa,
                                      input logic [7:0] opb, input logic [3:0] func);
        exp_q.delete();
        case (op)
            2'd0: begin exp_q = '{8'hAA, {4'h0, addr}, wdata};        exp_nrsp = 0; end
            2'd1: begin exp_q = '{8'hBB, {4'h0, addr}};               exp_nrsp = 1; end
            2'd2: begin exp_q = '{8'hCC, opa, opb, {4'h0, func}};     exp_nrsp = 2; end
            default: begin exp_q = '{8'hDD, {4'h0, func}};            exp_nrsp = 2; end
        endcase
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wdata,
                           input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] func,
                           input int bp, input int dly, input logic [7:0] r0, input logic [7:0] r1);
        logic [15:0] exp_rsp;
        int          hold;
        model_cmd(op, addr, wdata, opa, opb, func);
        exp_rsp = (exp_nrsp == 2) ? {r1, r0} : (exp_nrsp == 1) ? {8'h00, r0} : 16'h0000;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL op%0d ready_idle got=%b exp=1", op, cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
        cmd_opa = opa; cmd_opb = opb; cmd_func = func;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
        cmd_opa = 8'($urandom); cmd_opb = 8'($urandom); cmd_func = 4'($urandom);
        total++; if (rsp_data !== 16'h0 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL op%0d accept_clear rsp_data=%h ready=%b exp 0000/0", op, rsp_data, cmd_ready);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            hold = (bp < 0) ? int'($urandom_range(0, 2)) : bp;
            for (int h = 0; h <= hold; h++) begin
                total++; if (tx_d_valid !== 1'b1 || tx_p_data !== exp_q[i]) begin
                    bad++; $display("FAIL op%0d tx_byte%0d got v=%b d=%h exp v=1 d=%h", op, i, tx_d_valid, tx_p_data, exp_q[i]);
                end
                tx_ready = (h == hold);
                if (h == hold && i == exp_q.size() - 1) begin
                    rx_d_valid = 1'b1; rx_p_data = 8'($urandom);
                end
                @(negedge clk);
                tx_ready = 1'b0; rx_d_valid = 1'b0;
            end
        end
        total++; if (tx_d_valid !== 1'b0) begin bad++; $display("FAIL op%0d tx_idle_after got=%b exp=0", op, tx_d_valid); end
        for (int j = 0; j < exp_nrsp; j++) begin
            repeat (dly) begin
                total++; if (cmd_done !== 1'b0 || rsp_valid !== 1'b0) begin
                    bad++; $display("FAIL op%0d early_done done=%b rv=%b exp 0/0", op, cmd_done, rsp_valid);
                end
                @(negedge clk);
            end
            rx_d_valid = 1'b1; rx_p_data = (j == 0) ? r0 : r1;
            @(negedge clk);
            rx_d_valid = 1'b0;
        end
        total++; if (cmd_done !== 1'b1 || cmd_err !== 1'b0) begin
            bad++; $display("FAIL op%0d done got done=%b err=%b exp 1/0", op, cmd_done, cmd_err);
        end
        total++; if (rsp_valid !== (exp_nrsp != 0)) begin
            bad++; $display("FAIL op%0d rsp_valid got=%b exp=%b", op, rsp_valid, (exp_nrsp != 0));
        end
        total++; if (rsp_data !== exp_rsp) begin bad++; $display("FAIL op%0d rsp_data got=%h exp=%h", op, rsp_data, exp_rsp); end
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b1 || cmd_done !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== exp_rsp) begin
            bad++; $display("FAIL op%0d post_done ready=%b done=%b rv=%b rsp=%h exp 1/0/0/%h",
                            op, cmd_ready, cmd_done, rsp_valid, rsp_data, exp_rsp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_d_valid !== 1'b0 || tx_p_data !== 8'h0 || rsp_data !== 16'h0 || rsp_valid !== 1'b0 ||
                     cmd_done !== 1'b0 || cmd_err !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got tv=%b td=%h rsp=%h rv=%b done=%b err=%b exp all 0",
                            tx_d_valid, tx_p_data, rsp_data, rsp_valid, cmd_done, cmd_err);
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write();
        run_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_read();
        run_cmd(2'd1, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, 0, 20, 8'h5A, 8'h00);
    endtask

    task automatic test_alu();
        run_cmd(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2, 0, 2, 8'h46, 8'h00);
        run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 0, 1, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_backpressure();
        run_cmd(2'd2, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 3, 0,
                8'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 12; n++) begin
            run_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                    -1, int'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_opa = 8'h77; cmd_opb = 8'h88; cmd_func = 4'h9;
        @(negedge clk);
        cmd_valid = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_ready = 1'b0; rst = 1'b0;
        @(negedge clk);
        total++; if (tx_d_valid !== 1'b0 || tx_p_data !== 8'h0 || cmd_done !== 1'b0) begin
            bad++; $display("FAIL midreset got tv=%b td=%h done=%b exp 0/00/0", tx_d_valid, tx_p_data, cmd_done);
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || tx_d_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_release ready=%b tv=%b exp 1/0", cmd_ready, tx_d_valid);
        end
        run_cmd(2'd0, 4'($urandom), 8'($urandom), 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_timeout();
        logic [3:0] a;
        logic [7:0] rb;
        logic       seen;
        int         k;
        for (int pass = 0; pass < 2; pass++) begin
            a  = 4'($urandom);
            rb = 8'($urandom_range(1, 255));
            @(negedge clk);
            t_cmd_valid = 1'b1; t_cmd_op = (pass == 0) ? 2'd1 : 2'd3;
            t_cmd_addr = a; t_cmd_func = a; t_tx_ready = 1'b1;
            @(negedge clk);
            t_cmd_valid = 1'b0;
            total++; if (t_tx_d_valid !== 1'b1 || t_tx_p_data !== ((pass == 0) ? 8'hBB : 8'hDD)) begin
                bad++; $display("FAIL tmo%0d byte0 got v=%b d=%h", pass, t_tx_d_valid, t_tx_p_data);
            end
            @(negedge clk);
            total++; if (t_tx_d_valid !== 1'b1 || t_tx_p_data !== {4'h0, a}) begin
                bad++; $display("FAIL tmo%0d byte1 got v=%b d=%h exp 1/%h", pass, t_tx_d_valid, t_tx_p_data, {4'h0, a});
            end
            @(negedge clk);
            t_tx_ready = 1'b0;
            if (pass == 1) begin
                repeat (2) @(negedge clk);
                t_rx_d_valid = 1'b1; t_rx_p_data = rb;
                @(negedge clk);
                t_rx_d_valid = 1'b0;
            end
            seen = 1'b0; k = 1;
            while (t_cmd_done !== 1'b1 && k < 40) begin
                if (t_rsp_valid === 1'b1) seen = 1'b1;
                @(negedge clk);
                k++;
            end
            total++; if (k != 11) begin bad++; $display("FAIL tmo%0d latency got=%0d exp=11", pass, k); end
            total++; if (t_cmd_err !== 1'b1 || seen || t_rsp_valid !== 1'b0) begin
                bad++; $display("FAIL tmo%0d err=%b rv_seen=%b rv=%b exp 1/0/0", pass, t_cmd_err, seen, t_rsp_valid);
            end
            total++; if (t_rsp_data !== ((pass == 0) ? 16'h0 : {8'h00, rb})) begin
                bad++; $display("FAIL tmo%0d partial got=%h exp=%h", pass, t_rsp_data, (pass == 0) ? 16'h0 : {8'h00, rb});
            end
            @(negedge clk);
            t_rx_d_valid = 1'b1; t_rx_p_data = ~rb;
            @(negedge clk);
            t_rx_d_valid = 1'b0;
            @(negedge clk);
            total++; if (t_rsp_valid !== 1'b0 || t_cmd_ready !== 1'b1 || t_cmd_done !== 1'b0 ||
                         t_rsp_data !== ((pass == 0) ? 16'h0 : {8'h00, rb})) begin
                bad++; $display("FAIL tmo%0d late_byte rv=%b ready=%b done=%b rsp=%h", pass, t_rsp_valid,
                                t_cmd_ready, t_cmd_done, t_rsp_data);
            end
        end
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 4'h0; cmd_wdata = 8'h0;
        cmd_opa = 8'h0; cmd_opb = 8'h0; cmd_func = 4'h0; tx_ready = 1'b0; rx_d_valid = 1'b0; rx_p_data = 8'h0;
        t_cmd_valid = 1'b0; t_cmd_op = 2'd0; t_cmd_addr = 4'h0; t_cmd_wdata = 8'h0; t_cmd_opa = 8'h0;
        t_cmd_opb = 8'h0; t_cmd_func = 4'h0; t_tx_ready = 1'b0; t_rx_d_valid = 1'b0; t_rx_p_data = 8'h0;
        test_reset();
        test_write();
        test_read();
        test_alu();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
